// File: rtl/sram_req_arbiter_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sram_req_arbiter_if : SRAM-like request/response bus (one per port)
// Revision: 1.0
// ---------------------------------------------------------------------------
interface sram_req_arbiter_if;
    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] rdata;

    modport master (
        output req, wr, size, addr, wstrb, wdata,
        input  addr_ok, data_ok, rdata
    );

    modport slave (
        input  req, wr, size, addr, wstrb, wdata,
        output addr_ok, data_ok, rdata
    );
endinterface
`default_nettype wire

// File: rtl/sram_req_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sram_req_arbiter : data-first arbiter of inst/data requesters onto one
//                    SRAM-like port, with in-order ID FIFO for response routing
// Revision: 1.0
// ---------------------------------------------------------------------------
module sram_req_arbiter #(
    parameter int OUTSTANDING = 2,
    parameter int PTR_W       = 1
) (
    input  wire logic          clk_i,
    input  wire logic          reset_i,
    sram_req_arbiter_if.slave  inst_if,
    sram_req_arbiter_if.slave  data_if,
    sram_req_arbiter_if.master mem_if,
    output logic               busy_o,
    output logic               orphan_err_o
);
    localparam logic [PTR_W-1:0] c_last_ptr = PTR_W'(OUTSTANDING - 1);
    localparam logic [PTR_W:0]   c_depth    = (PTR_W + 1)'(OUTSTANDING);

    logic [OUTSTANDING-1:0] id_fifo_q;
    logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]         count_q, count_d;
    logic                   lock_vld_q, lock_vld_d, lock_id_q, lock_id_d;
    logic                   busy_q, orphan_q;
    logic                   w_full, w_gnt_vld, w_gnt_id, w_gnt_req;
    logic                   w_push, w_pop, w_head_id;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == c_last_ptr) ? '0 : p + 1'b1;
    endfunction

    // A locked grant keeps the memory payload stable until the handshake completes.
    always_comb begin
        w_gnt_vld = 1'b0;
        w_gnt_id  = 1'b0;
        if (!reset_i) begin
            if (lock_vld_q) begin
                w_gnt_vld = 1'b1;
                w_gnt_id  = lock_id_q;
            end else if (data_if.req) begin
                w_gnt_vld = 1'b1;
                w_gnt_id  = 1'b1;
            end else if (inst_if.req) begin
                w_gnt_vld = 1'b1;
                w_gnt_id  = 1'b0;
            end
        end
    end

    always_comb begin
        w_full    = (count_q == c_depth);
        w_gnt_req = w_gnt_vld && (w_gnt_id ? data_if.req : inst_if.req);
        mem_if.req   = w_gnt_req && !w_full;
        mem_if.wr    = 1'b0;
        mem_if.size  = 2'd0;
        mem_if.addr  = 32'd0;
        mem_if.wstrb = 4'd0;
        mem_if.wdata = 32'd0;
        if (w_gnt_vld && w_gnt_id) begin
            mem_if.wr    = data_if.wr;
            mem_if.size  = data_if.size;
            mem_if.addr  = data_if.addr;
            mem_if.wstrb = data_if.wstrb;
            mem_if.wdata = data_if.wdata;
        end else if (w_gnt_vld) begin
            mem_if.wr    = inst_if.wr;
            mem_if.size  = inst_if.size;
            mem_if.addr  = inst_if.addr;
            mem_if.wstrb = inst_if.wstrb;
            mem_if.wdata = inst_if.wdata;
        end
    end

    always_comb begin
        w_push    = mem_if.req && mem_if.addr_ok;
        w_pop     = mem_if.data_ok && (count_q != '0);
        w_head_id = id_fifo_q[rd_ptr_q];

        inst_if.addr_ok = w_push && !w_gnt_id;
        data_if.addr_ok = w_push &&  w_gnt_id;
        inst_if.data_ok = w_pop && !w_head_id;
        data_if.data_ok = w_pop &&  w_head_id;
        inst_if.rdata   = inst_if.data_ok ? mem_if.rdata : 32'd0;
        data_if.rdata   = data_if.data_ok ? mem_if.rdata : 32'd0;

        wr_ptr_d = w_push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = w_pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        count_d  = count_q;
        case ({w_push, w_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        lock_vld_d = mem_if.req && !mem_if.addr_ok;
        lock_id_d  = lock_vld_d ? w_gnt_id : 1'b0;
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            id_fifo_q  <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            lock_vld_q <= 1'b0;
            lock_id_q  <= 1'b0;
            busy_q     <= 1'b0;
            orphan_q   <= 1'b0;
        end else begin
            if (w_push) begin
                id_fifo_q[wr_ptr_q] <= w_gnt_id;
            end
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            lock_vld_q <= lock_vld_d;
            lock_id_q  <= lock_id_d;
            busy_q     <= (count_d != '0);
            if (mem_if.data_ok && (count_q == '0)) begin
                orphan_q <= 1'b1;
            end
        end
    end

    assign busy_o       = busy_q;
    assign orphan_err_o = orphan_q;
endmodule
`default_nettype wire

// File: tb/tb_sram_req_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_sram_req_arbiter : randomized scoreboard bench for sram_req_arbiter
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_sram_req_arbiter;
    localparam int OUTSTANDING = 2;

    typedef struct packed {
        logic        wr;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
    } pay_t;

    logic clk = 1'b0;
    logic rst;
    logic busy, orphan;
    always #5 clk = ~clk;

    sram_req_arbiter_if inst_if();
    sram_req_arbiter_if data_if();
    sram_req_arbiter_if mem_if();

    sram_req_arbiter #(.OUTSTANDING(OUTSTANDING), .PTR_W(1)) dut (
        .clk_i        (clk),
        .reset_i      (rst),
        .inst_if      (inst_if),
        .data_if      (data_if),
        .mem_if       (mem_if),
        .busy_o       (busy),
        .orphan_err_o (orphan)
    );

    logic        ireq, dreq, maok, mdok, orph_exp;
    pay_t        ipay, dpay;
    logic [31:0] mrdata;
    int          held, cnt;
    int          sbq[$];
    int          total = 0;
    int          bad   = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic pay_t rand_pay(input logic is_data);
        pay_t p;
        p.wr    = is_data ? 1'($urandom_range(1)) : 1'b0;
        p.size  = 2'($urandom_range(2));
        p.addr  = $urandom;
        p.wstrb = 4'($urandom_range(15));
        p.wdata = $urandom;
        return p;
    endfunction

    task automatic apply();
        inst_if.req = ireq;
        {inst_if.wr, inst_if.size, inst_if.addr, inst_if.wstrb, inst_if.wdata} = ipay;
        data_if.req = dreq;
        {data_if.wr, data_if.size, data_if.addr, data_if.wstrb, data_if.wdata} = dpay;
        mem_if.addr_ok = maok;
        mem_if.data_ok = mdok;
        mem_if.rdata   = mrdata;
    endtask

    // Reference: an offered-but-unaccepted request keeps ownership; otherwise data wins.
    task automatic model_check();
        int   owner, c0;
        logic oreq, exp_req, exp_acc;
        pay_t exp_pay, act_pay;
        c0      = cnt;
        owner   = (held >= 0) ? held : (dreq ? 1 : (ireq ? 0 : -1));
        oreq    = (owner == 1 && dreq) || (owner == 0 && ireq);
        exp_req = oreq && (c0 < OUTSTANDING);
        exp_pay = (owner == 1) ? dpay : ((owner == 0) ? ipay : '0);
        exp_acc = exp_req && maok;
        act_pay = {mem_if.wr, mem_if.size, mem_if.addr, mem_if.wstrb, mem_if.wdata};
        check("mem_req",      128'(mem_if.req),      128'(exp_req));
        check("mem_payload",  128'(act_pay),         128'(exp_pay));
        check("inst_addr_ok", 128'(inst_if.addr_ok), 128'(exp_acc && owner == 0));
        check("data_addr_ok", 128'(data_if.addr_ok), 128'(exp_acc && owner == 1));
        check("busy",         128'(busy),            128'(c0 != 0));
        check("orphan_err",   128'(orphan),          128'(orph_exp));
        if (exp_acc) begin
            sbq.push_back(owner);
            if (owner == 1) dreq = 1'b0; else ireq = 1'b0;
            held = -1;
        end else begin
            held = exp_req ? owner : -1;
        end
        if (mdok && c0 == 0) orph_exp = 1'b1;
        cnt = c0 + (exp_acc ? 1 : 0) - ((mdok && c0 > 0) ? 1 : 0);
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
        apply();
        @(negedge clk);
        model_check();
    endtask

    task automatic rand_cycle();
        if (!ireq && $urandom_range(2) == 0) begin ireq = 1'b1; ipay = rand_pay(1'b0); end
        if (!dreq && $urandom_range(2) == 0) begin dreq = 1'b1; dpay = rand_pay(1'b1); end
        maok   = 1'($urandom_range(1));
        mdok   = (cnt > 0) && ($urandom_range(2) == 0);
        mrdata = $urandom;
        cycle();
    endtask

    // Response monitor: pops the expected requester whenever a response appears.
    initial begin
        int id;
        forever begin
            @(negedge clk);
            if (!rst && (mem_if.data_ok || inst_if.data_ok || data_if.data_ok)) begin
                if (sbq.size() == 0) begin
                    check("orphan_route", 128'({inst_if.data_ok, data_if.data_ok}), 128'(2'b00));
                end else begin
                    id = sbq.pop_front();
                    check("resp_route", 128'({mem_if.data_ok, inst_if.data_ok, data_if.data_ok}),
                          128'({1'b1, id == 0, id == 1}));
                    check("resp_rdata", 128'({inst_if.rdata, data_if.rdata}),
                          (id == 1) ? 128'({32'h0, mem_if.rdata}) : 128'({mem_if.rdata, 32'h0}));
                end
            end
        end
    end

    initial begin
        int guard;
        rst = 1'b1;
        ireq = 0; dreq = 0; maok = 0; mdok = 0; mrdata = 0;
        ipay = '0; dpay = '0; held = -1; cnt = 0; orph_exp = 0;
        apply();
        repeat (2) @(posedge clk);
        #1;
        ireq = 1; dreq = 1; ipay = rand_pay(1'b0); dpay = rand_pay(1'b1); maok = 1; mdok = 1;
        apply();
        #1;
        check("rst_mem_req",   128'(mem_if.req), 128'(0));
        check("rst_addr_ok",   128'({inst_if.addr_ok, data_if.addr_ok}), 128'(0));
        check("rst_data_ok",   128'({inst_if.data_ok, data_if.data_ok}), 128'(0));
        check("rst_mem_addr",  128'(mem_if.addr), 128'(0));
        check("rst_busy",      128'(busy), 128'(0));
        check("rst_orphan",    128'(orphan), 128'(0));
        ireq = 0; dreq = 0; maok = 0; mdok = 0; ipay = '0; dpay = '0;
        apply();
        @(negedge clk);
        rst = 1'b0;

        // first instruction fetch, response two cycles later
        ireq = 1; ipay = '{wr: 1'b0, size: 2'd2, addr: 32'h1c000000, wstrb: 4'h0, wdata: 32'h0};
        maok = 1;
        cycle();
        maok = 0;
        cycle();
        mdok = 1; mrdata = 32'h02800000;
        cycle();
        mdok = 0;

        // simultaneous requests: data first, then inst
        dreq = 1; dpay = '{wr: 1'b1, size: 2'd2, addr: 32'h00001000, wstrb: 4'hf, wdata: 32'hcafef00d};
        ireq = 1; ipay = '{wr: 1'b0, size: 2'd2, addr: 32'h1c000004, wstrb: 4'h0, wdata: 32'h0};
        maok = 1;
        cycle();
        cycle();
        maok = 0; mdok = 1; mrdata = 32'h11111111;
        cycle();
        mrdata = 32'h22222222;
        cycle();
        mdok = 0;

        // inst locked while stalled, data arrives mid-stall
        ireq = 1; ipay = '{wr: 1'b0, size: 2'd2, addr: 32'h1c000008, wstrb: 4'h0, wdata: 32'h0};
        maok = 0;
        cycle();
        dreq = 1; dpay = '{wr: 1'b0, size: 2'd1, addr: 32'h00002002, wstrb: 4'h3, wdata: 32'h0};
        cycle();
        cycle();
        maok = 1;
        cycle();
        cycle();
        maok = 0; mdok = 1; mrdata = 32'h33333333;
        cycle();
        mrdata = 32'h44444444;
        cycle();
        mdok = 0;

        // orphan response with nothing outstanding
        mdok = 1; mrdata = 32'hdeadbeef;
        cycle();
        mdok = 0;
        cycle();

        repeat (2000) rand_cycle();

        guard = 0;
        while (cnt < OUTSTANDING && guard < 200) begin
            rand_cycle();
            guard++;
        end
        check("prefill_full", 128'(cnt), 128'(OUTSTANDING));

        // asynchronous reset mid-cycle with requests pending
        @(posedge clk);
        #1;
        if (!ireq) begin ireq = 1; ipay = rand_pay(1'b0); end
        maok = 0; mdok = 0;
        apply();
        #1 rst = 1'b1;
        #1;
        check("arst_busy",    128'(busy), 128'(0));
        check("arst_mem_req", 128'(mem_if.req), 128'(0));
        check("arst_addr_ok", 128'({inst_if.addr_ok, data_if.addr_ok}), 128'(0));
        check("arst_data_ok", 128'({inst_if.data_ok, data_if.data_ok}), 128'(0));
        check("arst_orphan",  128'(orphan), 128'(0));
        #1 rst = 1'b0;
        held = -1; cnt = 0; orph_exp = 0;
        sbq.delete();
        @(negedge clk);
        model_check();

        repeat (1000) rand_cycle();
        ireq = 0; dreq = 0; maok = 0;
        guard = 0;
        while (cnt > 0 && guard < 50) begin
            mdok = 1; mrdata = $urandom;
            cycle();
            guard++;
        end
        mdok = 0;
        cycle();
        check("drain_empty", 128'(sbq.size()), 128'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
